cpu_fetch_unit: RTL and testbench
=================================

// Module: cpu_fetch_unit
// PURPOSE
//  Instruction fetch stage with a prefetch queue, upstream of the CPU execute/state machine.
//  - Drives the instruction memory port with word addresses. Read latency is 1 cycle.
//  - Buffers returned words, tagged with their PC, in a small FIFO.
//  - Presents the words in order to the consumer over a valid/ready handshake.
//  - Accepts a redirect (branch/jump) that flushes all buffered and in-flight fetches.
// PARAMETERS
//  DEPTH     4      prefetch FIFO entries; legal range >=2, power of 2
//  RESET_PC  32'd0  fetch address after reset (word address)
// PORTS
//  aclk            in   1   clock
//  aresetn         in   1   reset
//  addr_inst       out  32  instruction memory word address
//  data_out_inst   out  32  write data; tied 32'd0 (fetch never writes)
//  data_in_inst    in   32  read data; valid the cycle after en_inst=1
//  en_inst         out  1   memory read enable
//  we_inst         out  1   write enable; tied 0
//  redirect_valid  in   1   flush and restart fetch at redirect_pc (1-cycle pulse)
//  redirect_pc     in   32  new fetch word address
//  inst_valid      out  1   inst_data/inst_pc hold a valid instruction
//  inst_data       out  32  instruction word (FIFO head)
//  inst_pc         out  32  word address of inst_data
//  inst_ready      in   1   consumer accepts the head this cycle
// BEHAVIOUR
//  Interface: reset aresetn, synchronous, active-low; clock aclk.
//  Reset (aresetn=0 at a posedge) forces the following, and it overrides any in-progress fetch:
//   - fetch_pc=RESET_PC, FIFO empty, inflight=0.
//   - Outputs: en_inst=0, inst_valid=0, inst_data=0, inst_pc=0, addr_inst=RESET_PC.
//  Internal state:
//   - fetch_pc: next address to request.
//   - inflight: 1-bit flag, "a read was issued last cycle".
//   - resp_pc: PC of the in-flight read.
//   - count: FIFO occupancy, range 0..DEPTH.
//  pop   = inst_valid & inst_ready.
//  issue = en_inst = aresetn & ~redirect_valid & ((count + inflight - pop) < DEPTH).
//   - Combinational from inst_ready; no overflow is possible by construction.
//  On issue:
//   - addr_inst = fetch_pc; fetch_pc <= fetch_pc+1, wrapping 32'hFFFF_FFFF -> 0.
//   - inflight <= 1; resp_pc <= fetch_pc.
//   - When not issuing, inflight <= 0.
//  Response: when inflight=1 and no redirect, {resp_pc, data_in_inst} is pushed at the end of that cycle.
//  Output: inst_valid/inst_data/inst_pc come from the registered FIFO head; no bypass.
//   - Latency from issue to inst_valid is 2 cycles.
//   - First instruction after reset release: en_inst=1 in the 1st cycle, inst_valid=1 in the 3rd.
//  Throughput: 1 instruction/cycle sustained while inst_ready=1, for any DEPTH>=2.
//  Handshake: the head is held stable while inst_valid=1 & inst_ready=0.
//   - inst_valid never deasserts without a pop, a redirect or a reset.
//  FIFO: a push and a pop in the same cycle is legal at any occupancy, including full; count is unchanged.
//  Redirect cycle:
//   - A pop in this cycle completes normally; the consumer owns that instruction.
//   - Then the FIFO is cleared and the returning response is discarded.
//   - inflight <= 0; fetch_pc <= redirect_pc; en_inst=0.
//   - The first fetch at redirect_pc is issued in the next cycle; inst_valid=0 until 2 cycles after that.
//  Back-to-back redirects: the last one wins, and no stale PC is ever presented.
// STRUCTURE
//  cpu_pkg holds:
//   - typedef logic [31:0] word_t.
//   - typedef struct packed {word_t pc; word_t inst;} fetch_entry_t.
//   - localparam word_t RESET_PC_DEFAULT.
//  One sub-module: cpu_sync_fifo.
//   - Parameters: type T, DEPTH.
//   - Ports: push, pop, clear, count, head.
//   - Registered head; sync reset; clear has priority over push.
//  Issue logic, inflight and fetch_pc stay in cpu_fetch_unit.
// TESTING
//  1. Reset release, inst_ready=1, mem[i]=32'hA000_0000+i:
//     -> en_inst in cycle 1 with addr 0.
//     -> inst_valid from cycle 3 with inst_pc 0,1,2,... and one instruction per cycle.
//  2. inst_ready=0 for 10 cycles with DEPTH=4:
//     -> exactly 4 reads are issued, then en_inst=0.
//     -> the head stays pc=0; after ready returns, pcs 0..3 arrive in order with no gap or duplicate.
//  3. Redirect to 32'h100 while the FIFO holds 3 entries and a read is in flight:
//     -> the next inst_valid shows inst_pc=32'h100 exactly 3 cycles after the redirect cycle.
//     -> no old PC appears afterwards.
//  4. Redirect in the same cycle as a pop of pc=5:
//     -> pc=5 is consumed; the next delivered pc is redirect_pc.
//  5. Random inst_ready with redirects at 10% probability, checked against a reference PC model:
//     -> no loss, duplication or reordering between redirects.
//  6. aresetn=0 mid-stream with a full FIFO:
//     -> the next cycle shows inst_valid=0, en_inst=0.
//     -> after release, fetch restarts at RESET_PC; a redirect to 32'hFFFF_FFFF wraps the next fetch to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the CPU front end: instruction words and PC-tagged fetch entries.
package cpu_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t inst;
  } fetch_entry_t;

  localparam word_t RESET_PC_DEFAULT = 32'd0;

endpackage

// File: rtl/cpu_fetch_unit_if.sv
// Bus bundle for the fetch unit: instruction memory port, redirect input and instruction stream.
interface cpu_fetch_unit_if;

  // Memory port: en_inst=1 requests addr_inst; data_in_inst is valid exactly one cycle later.
  logic [31:0] addr_inst;
  logic [31:0] data_out_inst;
  logic [31:0] data_in_inst;
  logic        en_inst;
  logic        we_inst;

  logic        redirect_valid;
  logic [31:0] redirect_pc;

  // Stream: a transfer happens when inst_valid & inst_ready at a clock edge; while inst_valid=1
  // and inst_ready=0 the producer holds inst_data/inst_pc stable and keeps inst_valid high.
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output addr_inst, data_out_inst, en_inst, we_inst,
    output inst_valid, inst_data, inst_pc,
    input  data_in_inst, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  addr_inst, data_out_inst, en_inst, we_inst,
    input  inst_valid, inst_data, inst_pc,
    output data_in_inst, redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/cpu_sync_fifo.sv
// Shift-register FIFO with a registered head at slot 0; clear beats push, push+pop legal when full.
module cpu_sync_fifo #(
  parameter type T     = logic [63:0],
  parameter int  DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  T              push_data_i,
  input  logic          pop_i,
  input  logic          clear_i,
  output logic [CW-1:0] count_o,
  output T              head_o
);

  localparam int IW = $clog2(DEPTH);

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] wr_idx;
  logic          pop_ok;
  logic          push_ok;

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    pop_ok  = pop_i & (count_q != '0);
    push_ok = push_i & ((count_q < CW'(DEPTH)) | pop_ok);
    // Write slot is computed after the shift so a simultaneous pop frees the tail slot.
    wr_idx  = IW'(count_q - CW'(pop_ok));
    if (clear_i) begin
      count_d = '0;
    end else begin
      if (pop_ok) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          mem_d[i] = mem_q[i+1];
        end
      end
      if (push_ok) begin
        mem_d[wr_idx] = push_data_i;
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[0];

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch stage: issues sequential word reads, queues PC-tagged responses, flushes on redirect.
module cpu_fetch_unit
  import cpu_pkg::*;
#(
  parameter int    DEPTH    = 4,
  parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
  input  logic             aclk,
  input  logic             aresetn,
  cpu_fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;

  word_t         fetch_pc_q, fetch_pc_d;
  word_t         resp_pc_q, resp_pc_d;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] count;
  logic [OW-1:0] occ;
  logic          pop;
  logic          issue;
  logic          push;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  assign pop = bus.inst_valid & bus.inst_ready;

  // Occupancy after this cycle's pop, counting the read already in flight, so a new read always has a slot.
  assign occ   = {1'b0, count} + OW'(inflight_q) - OW'(pop);
  assign issue = aresetn & ~bus.redirect_valid & (occ < OW'(DEPTH));

  // A response returning in a redirect cycle belongs to the old stream and is dropped.
  assign push       = inflight_q & ~bus.redirect_valid;
  assign push_entry = '{pc: resp_pc_q, inst: bus.data_in_inst};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = issue;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc;
      inflight_d = 1'b0;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + 32'd1;
      resp_pc_d  = fetch_pc_q;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
    end
  end

  cpu_sync_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (aclk),
    .rst_ni      (aresetn),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .clear_i     (bus.redirect_valid),
    .count_o     (count),
    .head_o      (head)
  );

  assign bus.en_inst       = issue;
  assign bus.addr_inst     = fetch_pc_q;
  assign bus.we_inst       = 1'b0;
  assign bus.data_out_inst = 32'd0;
  assign bus.inst_valid    = (count != '0);
  assign bus.inst_data     = head.inst;
  assign bus.inst_pc       = head.pc;

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Bench for cpu_fetch_unit: directed scenarios plus random ready/redirect traffic against a PC-stream model.
module tb_cpu_fetch_unit;
  import cpu_pkg::*;

  localparam int    DEPTH    = 4;
  localparam word_t RESET_PC = 32'd0;

  // ---------------- clock / reset ----------------
  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  logic rst_drv = 1'b0;
  always #5 aclk = ~aclk;

  cpu_fetch_unit_if bus ();

  cpu_fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  function automatic word_t mem_word(input word_t a);
    return 32'hA000_0000 + a;
  endfunction

  // Instruction memory: one-cycle read latency.
  always @(posedge aclk) begin
    if (bus.en_inst) bus.data_in_inst <= mem_word(bus.addr_inst);
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int passed = 0;
  logic [31:0] exp_q[$];

  word_t exp_pc;      // next PC the consumer must see
  word_t exp_fetch;   // next address the fetch port must request
  word_t last_pop_pc;
  int    issues;
  int    pops;
  logic  hold_pending;

  logic  obs_valid, obs_en;
  word_t obs_pc, obs_data, obs_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic ready, input logic redir, input word_t rpc);
    @(negedge aclk);
    aresetn            = rst_drv;
    bus.inst_ready     = ready;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    #1;
    obs_valid = bus.inst_valid;
    obs_pc    = bus.inst_pc;
    obs_data  = bus.inst_data;
    obs_en    = bus.en_inst;
    obs_addr  = bus.addr_inst;

    if (hold_pending) check("hold_valid", obs_valid, 1'b1);
    if (obs_valid === 1'b1) begin
      check("head_pc", obs_pc, exp_pc);
      check("head_data", obs_data, mem_word(exp_pc));
    end
    if (redir || !rst_drv) check("en_blocked", obs_en, 1'b0);
    if (obs_en === 1'b1) begin
      check("fetch_addr", obs_addr, exp_fetch);
      exp_fetch = exp_fetch + 32'd1;
      issues++;
    end
    if (obs_valid === 1'b1 && ready) begin
      last_pop_pc = obs_pc;
      pops++;
      exp_pc = exp_pc + 32'd1;
    end
    hold_pending = (obs_valid === 1'b1) && !ready && !redir && rst_drv;
    if (redir) begin
      exp_pc    = rpc;
      exp_fetch = rpc;
    end
    if (!rst_drv) begin
      exp_pc       = RESET_PC;
      exp_fetch    = RESET_PC;
      hold_pending = 1'b0;
    end
  endtask

  task automatic apply_reset();
    rst_drv = 1'b0;
    repeat (3) cycle(1'b0, 1'b0, 32'd0);
    rst_drv = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int got_pop;
    int pops_before;

    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    exp_pc       = RESET_PC;
    exp_fetch    = RESET_PC;
    last_pop_pc  = '0;
    issues       = 0;
    pops         = 0;
    hold_pending = 1'b0;
    repeat (2) @(posedge aclk);

    // Reset state
    apply_reset();
    check("rst_valid", obs_valid, 1'b0);
    check("rst_en", obs_en, 1'b0);
    check("rst_data", obs_data, 32'd0);
    check("rst_pc", obs_pc, 32'd0);
    check("rst_addr", obs_addr, RESET_PC);

    // 1: streaming from reset, one instruction per cycle from cycle 3
    cycle(1'b1, 1'b0, 32'd0);
    check("t1_en_c1", obs_en, 1'b1);
    check("t1_addr_c1", obs_addr, 32'd0);
    check("t1_valid_c1", obs_valid, 1'b0);
    cycle(1'b1, 1'b0, 32'd0);
    check("t1_valid_c2", obs_valid, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 32'd0);
      check("t1_stream_valid", obs_valid, 1'b1);
      check("t1_stream_pc", obs_pc, i);
    end

    // 2: consumer stalls; exactly DEPTH reads, then drain in order without gaps
    apply_reset();
    issues = 0;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'd0);
    check("t2_issues", issues, DEPTH);
    check("t2_en_stalled", obs_en, 1'b0);
    check("t2_head_pc", obs_pc, 32'd0);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(i);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 32'd0);
      check("t2_no_gap", obs_valid, 1'b1);
      if (exp_q.size() > 0) check("t2_order", last_pop_pc, exp_q.pop_front());
    end

    // 3: redirect with three entries queued and one read in flight
    apply_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 32'h100);
    check("t3_valid_before", obs_valid, 1'b1);
    cycle(1'b1, 1'b0, 32'd0);
    check("t3_gap1", obs_valid, 1'b0);
    cycle(1'b1, 1'b0, 32'd0);
    check("t3_gap2", obs_valid, 1'b0);
    cycle(1'b1, 1'b0, 32'd0);
    check("t3_valid_at3", obs_valid, 1'b1);
    check("t3_pc_at3", obs_pc, 32'h100);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'd0);

    // 4: redirect in the same cycle as the pop of pc 5
    apply_reset();
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 32'h200);
    check("t4_popped_pc", last_pop_pc, 32'd5);
    pops_before = pops;
    got_pop = 0;
    for (int i = 0; i < 10 && got_pop == 0; i++) begin
      cycle(1'b1, 1'b0, 32'd0);
      if (pops != pops_before) got_pop = 1;
    end
    check("t4_pop_seen", got_pop, 1);
    check("t4_next_pc", last_pop_pc, 32'h200);

    // 5: random ready with ~10% redirects
    pops_before = pops;
    for (int i = 0; i < 800; i++) begin
      logic rdy, rd;
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 9) == 0);
      cycle(rdy, rd, $urandom());
    end
    check("t5_progress", (pops - pops_before) > 100, 1'b1);

    // 6: reset mid-stream with a full queue, then wrap at the top of the address space
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'd0);
    check("t6_full_valid", obs_valid, 1'b1);
    check("t6_full_en", obs_en, 1'b0);
    rst_drv = 1'b0;
    cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    check("t6_rst_valid", obs_valid, 1'b0);
    check("t6_rst_en", obs_en, 1'b0);
    rst_drv = 1'b1;
    cycle(1'b1, 1'b0, 32'd0);
    check("t6_restart_en", obs_en, 1'b1);
    check("t6_restart_addr", obs_addr, RESET_PC);
    cycle(1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 32'hFFFF_FFFF);
    cycle(1'b1, 1'b0, 32'd0);
    check("t6_top_addr", obs_addr, 32'hFFFF_FFFF);
    cycle(1'b1, 1'b0, 32'd0);
    check("t6_wrap_en", obs_en, 1'b1);
    check("t6_wrap_addr", obs_addr, 32'd0);
    cycle(1'b1, 1'b0, 32'd0);
    check("t6_top_valid", obs_valid, 1'b1);
    check("t6_top_pc", obs_pc, 32'hFFFF_FFFF);
    cycle(1'b1, 1'b0, 32'd0);
    check("t6_wrap_pc", obs_pc, 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'd0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
